// File: rtl/uart_pkg.sv
// uart_pkg
// Definitions shared by the parameterised UART transmitter and its bench:
//   - uart_state_t : transmitter FSM states
//   - PARITY_*     : parity-mode encodings for the PARITY parameter
//   - IDX_W        : width of the data/stop bit index (covers up to 9 data bits)
//   - frame_cycles : clock cycles one complete frame occupies on the line
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    localparam int IDX_W = 4;

    function automatic int frame_cycles(input int data_bits,
                                        input int parity,
                                        input int stop_bits,
                                        input int clks_per_bit);
        return (1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits)
               * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick
// Bit-time strobe generator. Counts receiver_clk cycles while a frame is in
// flight and raises tick in the last cycle of every bit time.
// Ports:
//   receiver_clk : clock
//   rst_n        : asynchronous active-low reset
//   restart      : a word is being accepted; the next cycle is cycle 0 of a bit
//   run          : a frame is on the line; counter held at 0 otherwise
//   tick         : last cycle of the current bit time
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic receiver_clk,
    input  logic rst_n,
    input  logic restart,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // With CLKS_PER_BIT=1 LAST is 0, so every running cycle is a boundary.
    assign tick = run && (cnt == LAST);

    always_ff @(posedge receiver_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || !run || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param
// Parameterised UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional odd/even parity bit, STOP_BITS stop bits. Each bit lasts
// CLKS_PER_BIT cycles. A word offered in the last stop cycle starts the next
// frame with no idle gap.
// Ports:
//   receiver_clk : clock, all state changes on its rising edge
//   rst_n        : asynchronous active-low reset
//   tx_data      : word to send, captured on the accept edge
//   tx_valid     : tx_data is offered
//   tx_ready     : a word is accepted on this edge if tx_valid is high
//   tx           : registered serial line, idle high
//   busy         : a frame is on the line
//   frame_done   : one-cycle pulse in the cycle after the last stop cycle
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 receiver_clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    uart_state_t            state;
    uart_state_t            state_nxt;
    logic [IDX_W-1:0]       bit_idx;
    logic [IDX_W-1:0]       idx_nxt;
    logic [DATA_BITS-1:0]   data_p0;
    logic [DATA_BITS-1:0]   data_nxt;
    logic                   tx_p0;
    logic                   tx_nxt;
    logic                   frame_done_p0;
    logic                   tick;
    logic                   frame_end;
    logic                   accept;

    function automatic logic bit_sel(input logic [DATA_BITS-1:0] d,
                                     input logic [IDX_W-1:0]     i);
        logic [DATA_BITS-1:0] s;
        s = d >> i;
        return s[0];
    endfunction

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        return (PARITY == PARITY_ODD) ? ~(^d) : (^d);
    endfunction

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .receiver_clk(receiver_clk),
        .rst_n       (rst_n),
        .restart     (accept),
        .run         (busy),
        .tick        (tick)
    );

    assign accept     = tx_valid && tx_ready;
    assign tx         = tx_p0;
    assign frame_done = frame_done_p0;

    // ---- stage p0: state, bit index, captured word and line register ----
    always_ff @(posedge receiver_clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            bit_idx       <= '0;
            data_p0       <= '0;
            tx_p0         <= 1'b1;
            frame_done_p0 <= 1'b0;
        end else begin
            state         <= state_nxt;
            bit_idx       <= idx_nxt;
            data_p0       <= data_nxt;
            tx_p0         <= tx_nxt;
            frame_done_p0 <= frame_end;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = bit_idx;
        data_nxt  = accept ? tx_data : data_p0;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_START;
                    idx_nxt   = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_nxt = ST_DATA;
                    idx_nxt   = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_idx == LAST_DATA) begin
                        idx_nxt   = '0;
                        state_nxt = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_nxt = bit_idx + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_nxt = ST_STOP;
                    idx_nxt   = '0;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (bit_idx == LAST_STOP) begin
                        // A word taken in the last stop cycle goes straight to START.
                        idx_nxt   = '0;
                        state_nxt = accept ? ST_START : ST_IDLE;
                    end else begin
                        idx_nxt = bit_idx + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                idx_nxt   = '0;
            end
        endcase

        // The line register is loaded with the level of the bit being entered,
        // so tx changes exactly on the bit boundary and never glitches.
        case (state_nxt)
            ST_START:  tx_nxt = 1'b0;
            ST_DATA:   tx_nxt = bit_sel(data_nxt, idx_nxt);
            ST_PARITY: tx_nxt = parity_bit(data_nxt);
            default:   tx_nxt = 1'b1;
        endcase
    end

    always_comb begin
        frame_end = (state == ST_STOP) && tick && (bit_idx == LAST_STOP);
        tx_ready  = (state == ST_IDLE) || frame_end;
        busy      = (state != ST_IDLE);
    end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter DATA_BITS, default 8, data bits per frame; legal range 4..9.
REQ-002 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit time; legal value >= 1.
REQ-003 Parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-005 Port receiver_clk, input, 1, single clock; all state changes on its rising edge.
REQ-006 Port rst_n, input, 1, asynchronous active-low reset.
REQ-007 Port tx_data, input, DATA_BITS, parallel word to send.
REQ-008 Port tx_valid, input, 1, word on tx_data is offered.
REQ-009 Port tx_ready, output, 1, block accepts a word on this edge when tx_valid is high.
REQ-010 Port tx, output, 1, serial line; idle level high.
REQ-011 Port busy, output, 1, high while a frame is on the line.
REQ-012 Port frame_done, output, 1, one-cycle pulse at the end of each frame.

Function
REQ-013 Accept occurs on a rising edge where tx_valid and tx_ready are both high; tx_data is registered on that edge, and later changes to tx_data do not affect the frame.
REQ-014 Frame order: 1 start bit (0), DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits (1).
REQ-015 Each bit holds tx for exactly CLKS_PER_BIT cycles; frame length is (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
REQ-016 tx goes low in the first cycle after the accept edge (latency 1 cycle).
REQ-017 FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on accept.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> PARITY, or DATA -> STOP when PARITY=0, after DATA_BITS bit times.
  - PARITY -> STOP after 1 bit time.
  - STOP -> IDLE after STOP_BITS bit times.
REQ-018 Parity bit = XOR of the registered data bits for even mode, and its inverse for odd mode.
REQ-019 tx_ready is high in IDLE and in the final cycle of the last stop bit, and low otherwise.
REQ-020 An accept in the final stop cycle starts the next start bit on the following cycle, with no idle gap and no extra high cycle.
REQ-021 busy is high from the cycle after accept through the final stop cycle inclusive.
  - busy stays high across back-to-back frames.
REQ-022 frame_done pulses high for one cycle, in the cycle after the final stop-bit cycle, whether or not a new frame was accepted.
REQ-023 tx_valid high while tx_ready is low has no effect; no word is queued.
REQ-024 Bit-time counter width is max(1, $clog2(CLKS_PER_BIT)); it wraps to 0 at CLKS_PER_BIT-1.
  - With CLKS_PER_BIT=1, every cycle is a bit boundary.
REQ-025 tx is driven from a register, so it is glitch-free.

Reset
REQ-026 On rst_n low, immediately and independent of the clock, the block goes to:
  - FSM in IDLE;
  - tx = 1, tx_ready = 1, busy = 0, frame_done = 0;
  - counters and data register = 0.
REQ-027 Reset asserted mid-frame aborts the frame; tx returns high with no partial stop sequence.
REQ-028 After rst_n deasserts, the first accept is possible on the first rising edge.

Structure
REQ-029 Package uart_pkg holds:
  - the FSM state enum;
  - parity-mode constants PARITY_NONE/ODD/EVEN;
  - a function computing frame length in cycles.
REQ-030 Sub-module uart_baud_tick (parameter CLKS_PER_BIT) generates a bit-boundary strobe.
  - The strobe restarts on accept.

Verification
REQ-031 DATA_BITS=8, CLKS_PER_BIT=4, PARITY=2, 1 stop, tx_data=0xA5:
  - tx = 0, then 1,0,1,0,0,1,0,1, then parity 0, then stop 1;
  - each bit lasts 4 cycles, 44 cycles total;
  - frame_done pulses once.
REQ-032 Same config with PARITY=1 and tx_data=0x07: parity bit = 0; with PARITY=2: parity bit = 1.
REQ-033 Back-to-back: tx_valid held high with 0x55 then 0x0F.
  - Second start bit immediately follows the first frame's stop bit.
  - busy is never low between the frames.
REQ-034 DATA_BITS=4, PARITY=0, STOP_BITS=2, CLKS_PER_BIT=1, tx_data=4'b1011 -> tx sequence 0,1,1,0,1,1,1, then idle high.
REQ-035 Reset mid-frame: rst_n low during data bit 3 of 0xA5.
  - tx goes high and tx_ready goes high asynchronously.
  - No frame_done pulse.
  - A new 0x3C frame sends correctly after release.
REQ-036 tx_valid pulsed with 0xFF during busy -> ignored; only the original frame is transmitted.
